// File: rtl/slb_pkg.sv
// Shared configuration for the store/load buffer slice.
// - Bus widths for opcodes, ROB nicks, data and addresses.
// - Memory opcode encodings (LB..SW) and memory access length codes.
// - FSM state type and small opcode decode helpers.
package slb_pkg;

  localparam int SLB_NUM = 16;  // queue entries
  localparam int OP_W    = 4;
  localparam int NICK_W  = 5;   // nick 0 means "operand already valid"
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;

  localparam logic [OP_W-1:0] OP_LB  = 4'd1;
  localparam logic [OP_W-1:0] OP_LH  = 4'd2;
  localparam logic [OP_W-1:0] OP_LW  = 4'd3;
  localparam logic [OP_W-1:0] OP_LBU = 4'd4;
  localparam logic [OP_W-1:0] OP_LHU = 4'd5;
  localparam logic [OP_W-1:0] OP_SB  = 4'd6;
  localparam logic [OP_W-1:0] OP_SH  = 4'd7;
  localparam logic [OP_W-1:0] OP_SW  = 4'd8;

  localparam logic [1:0] MEM_LEN_BYTE = 2'd0;
  localparam logic [1:0] MEM_LEN_HALF = 2'd1;
  localparam logic [1:0] MEM_LEN_WORD = 2'd2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } slb_state_e;

  function automatic logic op_is_store(input logic [OP_W-1:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic [1:0] op_len(input logic [OP_W-1:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return MEM_LEN_BYTE;
      OP_LH, OP_LHU, OP_SH: return MEM_LEN_HALF;
      default:              return MEM_LEN_WORD;
    endcase
  endfunction

endpackage

// File: rtl/slb_ld_ext.sv
// Load result extension (combinational).
// - op  : load opcode of the entry being completed
// - raw : raw data from the memory controller (already zero-extended)
// - ext : LB/LH sign-extended from bit 7/15, LBU/LHU zero-extended, LW unchanged
module slb_ld_ext
  import slb_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] raw,
  output logic [DATA_W-1:0] ext
);

  always_comb begin
    ext = raw;
    case (op)
      OP_LB:   ext = {{24{raw[7]}}, raw[7:0]};
      OP_LH:   ext = {{16{raw[15]}}, raw[15:0]};
      OP_LBU:  ext = {24'd0, raw[7:0]};
      OP_LHU:  ext = {16'd0, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/slb.sv
// In-order store/load buffer between dispatch and the memory controller.
// Ports:
// - clk, rst (sync, active-high), rdy (global stall when low), clr (mispredict flush)
// - oINF_full, iDP_*        : dispatch of memory ops into the circular queue
// - iEX_*                   : ALU result broadcast used for operand wakeup
// - iROB_store_*            : ROB store-commit pulse (this block is the responder)
// - oMC_*, iMC_done, iMC_dt : memory controller request/complete
// - oSLB_*                  : result/ack broadcast to ROB and CDB (also snooped here)
// - dbg_state/count/head/tail : internal state for observation
// Handshakes: a dispatch is taken on any cycle with iDP_en=1 and oINF_full=0 (and no clr,
// rdy=1). oMC_en rises one cycle after the issue decision and stays high, with stable
// fields, until the cycle iMC_done is seen; that cycle pops the head, and the next cycle
// carries a one-cycle oSLB_en pulse. iMC_done seen while rdy=0 is latched and consumed
// once rdy returns.
module slb
  import slb_pkg::*;
#(
  parameter int DEPTH = SLB_NUM,
  parameter int PTR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clr,
  output logic              oINF_full,
  input  logic              iDP_en,
  input  logic [OP_W-1:0]   iDP_op,
  input  logic [NICK_W-1:0] iDP_rs1_nick,
  input  logic [DATA_W-1:0] iDP_rs1_dt,
  input  logic [NICK_W-1:0] iDP_rs2_nick,
  input  logic [DATA_W-1:0] iDP_rs2_dt,
  input  logic [DATA_W-1:0] iDP_imm,
  input  logic [NICK_W-1:0] iDP_rd_nick,
  input  logic              iEX_en,
  input  logic [NICK_W-1:0] iEX_nick,
  input  logic [DATA_W-1:0] iEX_dt,
  input  logic              iROB_store_en,
  input  logic [NICK_W-1:0] iROB_store_nick,
  output logic              oMC_en,
  output logic              oMC_wr,
  output logic [ADDR_W-1:0] oMC_addr,
  output logic [DATA_W-1:0] oMC_dt,
  output logic [1:0]        oMC_len,
  input  logic              iMC_done,
  input  logic [DATA_W-1:0] iMC_dt,
  output logic              oSLB_en,
  output logic [NICK_W-1:0] oSLB_nick,
  output logic [DATA_W-1:0] oSLB_dt,
  output slb_state_e        dbg_state,
  output logic [PTR_W:0]    dbg_count,
  output logic [PTR_W-1:0]  dbg_head,
  output logic [PTR_W-1:0]  dbg_tail
);

  logic [DEPTH-1:0]  q_valid;
  logic [DEPTH-1:0]  q_commit;
  logic [OP_W-1:0]   q_op       [DEPTH];
  logic [NICK_W-1:0] q_rs1_nick [DEPTH];
  logic [DATA_W-1:0] q_rs1_dt   [DEPTH];
  logic [NICK_W-1:0] q_rs2_nick [DEPTH];
  logic [DATA_W-1:0] q_rs2_dt   [DEPTH];
  logic [DATA_W-1:0] q_imm      [DEPTH];
  logic [NICK_W-1:0] q_rd_nick  [DEPTH];

  logic [PTR_W-1:0]  head, tail;
  logic [PTR_W:0]    count;
  slb_state_e        state;
  logic              req_kill;   // in-flight load was flushed: complete silently
  logic              done_pend;  // iMC_done seen during a stall
  logic [DATA_W-1:0] pend_dt;

  logic              push, pop, done, head_store, head_ready;
  logic [DATA_W-1:0] mc_raw, ld_val;
  logic [PTR_W:0]    keep_cnt;
  logic              keep_run;
  logic [DEPTH-1:0]  keep_mask;

  assign oINF_full  = (count == (PTR_W+1)'(DEPTH));
  assign push       = iDP_en && !oINF_full && !clr;
  assign done       = iMC_done || done_pend;
  assign pop        = (state == S_REQ) && done;
  assign mc_raw     = done_pend ? pend_dt : iMC_dt;
  assign head_store = op_is_store(q_op[head]);
  assign head_ready = q_valid[head] && (q_rs1_nick[head] == '0) &&
                      (q_rs2_nick[head] == '0) && (!head_store || q_commit[head]);

  assign dbg_state = state;
  assign dbg_count = count;
  assign dbg_head  = head;
  assign dbg_tail  = tail;

  slb_ld_ext u_ld_ext (
    .op  (q_op[head]),
    .raw (mc_raw),
    .ext (ld_val)
  );

  // Entries surviving a flush: the in-flight head (if any) followed by the run of
  // committed stores directly behind the head. Everything after the first
  // uncommitted op is younger than the mispredict and is discarded.
  always_comb begin
    keep_cnt = '0;
    keep_run = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      if (keep_run && (k < int'(count)) &&
          (q_commit[head + PTR_W'(k)] || (k == 0 && state == S_REQ)))
        keep_cnt = keep_cnt + 1'b1;
      else
        keep_run = 1'b0;
    end
    for (int i = 0; i < DEPTH; i++)
      keep_mask[i] = ({1'b0, PTR_W'(i) - head} < keep_cnt);
  end

  function automatic logic wake_hit_ex(input logic [NICK_W-1:0] n);
    return iEX_en && (n != '0) && (n == iEX_nick);
  endfunction

  function automatic logic wake_hit_slb(input logic [NICK_W-1:0] n);
    return oSLB_en && (n != '0) && (n == oSLB_nick);
  endfunction

  function automatic logic [NICK_W-1:0] wake_nick(input logic [NICK_W-1:0] n);
    return (wake_hit_ex(n) || wake_hit_slb(n)) ? '0 : n;
  endfunction

  function automatic logic [DATA_W-1:0] wake_dt(input logic [NICK_W-1:0] n,
                                                input logic [DATA_W-1:0] d);
    if (wake_hit_ex(n))  return iEX_dt;
    if (wake_hit_slb(n)) return oSLB_dt;
    return d;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      q_valid   <= '0;
      q_commit  <= '0;
      state     <= S_IDLE;
      req_kill  <= 1'b0;
      done_pend <= 1'b0;
      pend_dt   <= '0;
      oMC_en    <= 1'b0;
      oMC_wr    <= 1'b0;
      oMC_addr  <= '0;
      oMC_dt    <= '0;
      oMC_len   <= '0;
      oSLB_en   <= 1'b0;
      oSLB_nick <= '0;
      oSLB_dt   <= '0;
    end else if (!rdy) begin
      if (iMC_done) begin
        done_pend <= 1'b1;
        pend_dt   <= iMC_dt;
      end
    end else begin
      done_pend <= 1'b0;
      oSLB_en   <= 1'b0;
      oSLB_nick <= '0;
      oSLB_dt   <= '0;

      // Operand wakeup and store commit on resident entries.
      for (int i = 0; i < DEPTH; i++) begin
        if (q_valid[i]) begin
          q_rs1_nick[i] <= wake_nick(q_rs1_nick[i]);
          q_rs1_dt[i]   <= wake_dt(q_rs1_nick[i], q_rs1_dt[i]);
          q_rs2_nick[i] <= wake_nick(q_rs2_nick[i]);
          q_rs2_dt[i]   <= wake_dt(q_rs2_nick[i], q_rs2_dt[i]);
          if (iROB_store_en && op_is_store(q_op[i]) && (q_rd_nick[i] == iROB_store_nick))
            q_commit[i] <= 1'b1;
        end
      end

      // Dispatch with same-cycle wakeup/commit bypass.
      if (push) begin
        q_valid[tail]    <= 1'b1;
        q_commit[tail]   <= iROB_store_en && op_is_store(iDP_op) &&
                            (iDP_rd_nick == iROB_store_nick);
        q_op[tail]       <= iDP_op;
        q_rs1_nick[tail] <= wake_nick(iDP_rs1_nick);
        q_rs1_dt[tail]   <= wake_dt(iDP_rs1_nick, iDP_rs1_dt);
        q_rs2_nick[tail] <= wake_nick(iDP_rs2_nick);
        q_rs2_dt[tail]   <= wake_dt(iDP_rs2_nick, iDP_rs2_dt);
        q_imm[tail]      <= iDP_imm;
        q_rd_nick[tail]  <= iDP_rd_nick;
      end

      case (state)
        S_IDLE: begin
          // A flushing cycle never issues; a surviving committed store issues next cycle.
          if (head_ready && !clr) begin
            state    <= S_REQ;
            oMC_en   <= 1'b1;
            oMC_wr   <= head_store;
            oMC_addr <= q_rs1_dt[head] + q_imm[head];
            oMC_dt   <= head_store ? q_rs2_dt[head] : '0;
            oMC_len  <= op_len(q_op[head]);
          end
        end
        S_REQ: begin
          if (done) begin
            state          <= S_IDLE;
            oMC_en         <= 1'b0;
            req_kill       <= 1'b0;
            q_valid[head]  <= 1'b0;
            q_commit[head] <= 1'b0;
            head           <= head + 1'b1;
            if (head_store) begin
              oSLB_en   <= 1'b1;
              oSLB_nick <= q_rd_nick[head];
            end else if (!req_kill && !clr) begin
              oSLB_en   <= 1'b1;
              oSLB_nick <= q_rd_nick[head];
              oSLB_dt   <= ld_val;
            end
          end else if (clr && !head_store) begin
            req_kill <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (clr) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (!keep_mask[i]) begin
            q_valid[i]  <= 1'b0;
            q_commit[i] <= 1'b0;
          end
        end
        tail  <= head + keep_cnt[PTR_W-1:0];
        count <= keep_cnt - {{PTR_W{1'b0}}, pop};
      end else begin
        tail  <= tail + {{(PTR_W-1){1'b0}}, push};
        count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
      end
    end
  end

endmodule
